key_debounce_toggle: RTL and testbench
======================================

# key_debounce_toggle

Upstream conditioning stage for the board push-buttons feeding the key/switch LED display, whose `key` input is the 4-bit `key` bus defined here. Each raw button is synchronized and debounced. The block produces:
- a stable level;
- one-cycle press and release pulses;
- a per-key toggle latch, which is the value normally routed to the display's key nibble.

## Interface
- `N_KEYS`, default 4: number of independent button channels.
- `CNT_MAX`, default 20000: consecutive stable cycles required to accept a level change. Legal range is ≥2; 20000 equals 1 ms at 20 MHz.
- `clk` input 1: single system clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `key_raw` input N_KEYS: raw button levels, 1 = pressed; asynchronous to `clk`, bouncing.
- `key_stable` output N_KEYS: debounced level, 1 = pressed.
- `key_press` output N_KEYS: one-cycle pulse on an accepted 0→1 transition.
- `key_release` output N_KEYS: one-cycle pulse on an accepted 1→0 transition.
- `key_toggle` output N_KEYS: flips on every accepted press; drives the display's `key` input.

## Operation
- Channels are fully independent. There is no cross-channel priority or interaction.
- Each channel passes `key_raw[i]` through a 2-flop synchronizer to form `s`. The first flop resets to 0.
- Per-channel state machine:
  - **RELEASED**: if `s`=1, go to PRESS_WAIT and set cnt←0.
  - **PRESS_WAIT**:
    - if `s`=0, return to RELEASED (bounce abort, no pulse);
    - else if cnt==CNT_MAX−1, go to PRESSED, assert `key_press` and set `key_stable`←1;
    - else cnt←cnt+1.
  - **PRESSED**: if `s`=0, go to RELEASE_WAIT and set cnt←0.
  - **RELEASE_WAIT**: symmetric to PRESS_WAIT, with the polarity inverted.
    - A glitch high aborts back to PRESSED.
    - Acceptance goes to RELEASED, asserts `key_release` and sets `key_stable`←0.
- Counter width is $clog2(CNT_MAX). The counter never exceeds CNT_MAX−1 and never wraps.
- `key_toggle[i]` inverts in the same edge that asserts `key_press[i]`. Releases do not affect it.
- All outputs are registered. No combinational path exists from `key_raw` to any output.

## Timing
- Reset (asynchronous, any time):
  - all states return to RELEASED;
  - cnt=0, synchronizer flops=0;
  - `key_stable`=0, `key_press`=0, `key_release`=0, `key_toggle`=0.
- A press in progress is discarded on reset; no pulse is emitted. After reset deasserts, a key held down is accepted as a fresh press after the full latency.
- Latency: if `key_raw[i]` is first sampled high at edge E0 and stays high, then `key_press[i]` and the rise of `key_stable[i]` appear after edge E0+CNT_MAX+2. Release latency is identical.
- `key_press` and `key_release` are high for exactly one cycle per accepted transition. They are never both high on the same channel.
- A low sample inside PRESS_WAIT restarts qualification from RELEASED. Acceptance therefore needs CNT_MAX consecutive high samples of `s` after entry.
- A key held indefinitely produces no further pulses. There is no auto-repeat.
- Simultaneous presses on several channels produce pulses on those channels in the same cycle.

## Structure
- Shared package `key_pkg`:
  - 2-bit state encodings `ST_RELEASED`=0, `ST_PRESS_WAIT`=1, `ST_PRESSED`=2, `ST_RELEASE_WAIT`=3;
  - default `CNT_MAX`.
- Sub-module `key_debounce_ch`: one channel holding the synchronizer, counter, state machine and toggle flop. The top level instantiates it N_KEYS times in a generate loop, passing `CNT_MAX`.
- The display stage consumes `key_toggle`. `key_press` and `key_release` are available for future counter and menu blocks.

## Test plan
All scenarios use CNT_MAX=4.
- **Clean press:** `key_raw`=4'b0001 from edge 10 and held → `key_press`=4'b0001 for one cycle after edge 16; `key_stable[0]`=1 and `key_toggle[0]`=1 from then on; no other bits change.
- **Bounce:** `key_raw[1]` pattern 1,0,1,1,0,1 on consecutive edges, then held 1 → no pulse during the bounce; exactly one `key_press[1]`, 6 edges after the last 0→1 sample.
- **Release and toggle:** two full press/release cycles on `key_raw[2]` → two `key_press[2]` and two `key_release[2]` pulses; `key_toggle[2]` goes 0→1→0; `key_stable[2]` follows each accepted level.
- **Short glitch:** a 3-cycle high pulse on `key_raw[3]` → no output activity on any channel.
- **Simultaneous:** `key_raw`=4'b1111 at one edge, held → `key_press`=4'b1111 in a single cycle; `key_toggle`=4'b1111.
- **Reset mid-operation:** `rst` asserted asynchronously between clock edges while channel 0 is in PRESS_WAIT with `key_toggle`=4'b0101 → all outputs 0 immediately; after release of `rst`, with the key still held, `key_press[0]` appears after edge E0+6.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioning blocks: channel state
// encoding and the default qualification length (1 ms at 20 MHz).
package key_pkg;

  localparam int CNT_MAX_DEFAULT = 20000;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchronizer, qualification counter, debounce
// state machine and the press-driven toggle latch. All outputs are registered.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_stable,
  output logic key_press,
  output logic key_release,
  output logic key_toggle
);

  localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic          sync1;
  logic          s;
  key_state_t    state;
  key_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          press_nxt;
  logic          release_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= key_raw;
      s     <= sync1;
    end
  end

  // State register; the pulses, stable level and toggle are registered here
  // too so nothing downstream sees a combinational path from the raw pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RELEASED;
      cnt         <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_stable  <= 1'b0;
      key_toggle  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      if (press_nxt)
        key_stable <= 1'b1;
      else if (release_nxt)
        key_stable <= 1'b0;
      if (press_nxt)
        key_toggle <= ~key_toggle;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RELEASED: begin
        if (s) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s)
          state_nxt = ST_RELEASED;
        else if (cnt == CNT_LAST)
          state_nxt = ST_PRESSED;
        else
          cnt_nxt = cnt + CW'(1);
      end
      ST_PRESSED: begin
        if (!s) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (s)
          state_nxt = ST_PRESSED;
        else if (cnt == CNT_LAST)
          state_nxt = ST_RELEASED;
        else
          cnt_nxt = cnt + CW'(1);
      end
      default: begin
        state_nxt = ST_RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pulses fire on the edge that completes qualification in either direction.
  always_comb begin
    press_nxt   = (state == ST_PRESS_WAIT) && s && (cnt == CNT_LAST);
    release_nxt = (state == ST_RELEASE_WAIT) && !s && (cnt == CNT_LAST);
  end

endmodule

// File: rtl/key_debounce_toggle.sv
// Push-button conditioning for the key/switch LED display: N_KEYS independent
// debounced channels; key_toggle feeds the display's key nibble.
module key_debounce_toggle
  import key_pkg::*;
#(
  parameter int N_KEYS  = 4,
  parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_stable,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_toggle
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX(CNT_MAX)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key_raw    (key_raw[i]),
      .key_stable (key_stable[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_toggle (key_toggle[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_toggle.sv
// Bench for key_debounce_toggle: directed scenarios plus random bouncing,
// checked every cycle against a run-length acceptance model.
module tb_key_debounce_toggle;

  localparam int NK = 4;
  localparam int CM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] key_raw = '0;
  logic [NK-1:0] key_stable;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_toggle;

  int checks = 0;
  int errors = 0;

  // Reference: a channel accepts a new level once the synchronized input has
  // disagreed with the accepted level on CM+1 consecutive edges.
  logic [NK-1:0] m_s1, m_s2, m_stable, m_toggle, m_press, m_release;
  int            m_run [NK];
  int            press_cnt [NK];

  key_debounce_toggle #(.N_KEYS(NK), .CNT_MAX(CM)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_stable (key_stable),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_toggle = '0;
    m_press = '0; m_release = '0;
    for (int i = 0; i < NK; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    for (int i = 0; i < NK; i++) begin
      m_press[i]   = 1'b0;
      m_release[i] = 1'b0;
      if (m_s2[i] != m_stable[i]) m_run[i] = m_run[i] + 1;
      else                        m_run[i] = 0;
      if (m_run[i] == CM + 1) begin
        m_run[i] = 0;
        if (m_stable[i]) m_release[i] = 1'b1;
        else begin
          m_press[i]  = 1'b1;
          m_toggle[i] = ~m_toggle[i];
        end
        m_stable[i] = ~m_stable[i];
      end
    end
    m_s2 = m_s1;
    m_s1 = key_raw;
  endtask

  task automatic check_one(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_one({tag, "_stable"},  key_stable,  m_stable);
    check_one({tag, "_press"},   key_press,   m_press);
    check_one({tag, "_release"}, key_release, m_release);
    check_one({tag, "_toggle"},  key_toggle,  m_toggle);
  endtask

  // Drive a level, then run edges with the model stepping and checking each one.
  task automatic apply_stimulus(input logic [NK-1:0] value, input int cycles, input string tag);
    key_raw = value;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      model_step();
      #1;
      for (int i = 0; i < NK; i++) if (key_press[i]) press_cnt[i]++;
      check_output(tag);
    end
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      logic [NK-1:0] v;
      v = key_raw;
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 7) == 0) v[i] = ~v[i];
      apply_stimulus(v, 1, "random");
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NK; i++) press_cnt[i] = 0;

    #1 rst = 1'b1;
    #2 check_output("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    apply_stimulus(4'b0000, 3, "idle");

    // Clean press on channel 0, held; press appears 6 edges after first sample
    apply_stimulus(4'b0001, 12, "clean");
    check_one("clean_press_count", 4'(press_cnt[0]), 4'd1);
    check_one("clean_toggle0", key_toggle & 4'b0001, 4'b0001);

    // Bounce on channel 1 while channel 0 stays held
    apply_stimulus(4'b0011, 1, "bounce");
    apply_stimulus(4'b0001, 1, "bounce");
    apply_stimulus(4'b0011, 2, "bounce");
    apply_stimulus(4'b0001, 1, "bounce");
    apply_stimulus(4'b0011, 12, "bounce");
    check_one("bounce_press_count", 4'(press_cnt[1]), 4'd1);

    // Two full press/release cycles on channel 2 (and release of 0,1)
    apply_stimulus(4'b0100, 10, "cycle");
    apply_stimulus(4'b0000, 10, "cycle");
    apply_stimulus(4'b0100, 10, "cycle");
    apply_stimulus(4'b0000, 10, "cycle");
    check_one("cycle_press_count", 4'(press_cnt[2]), 4'd2);
    check_one("cycle_toggle2", key_toggle & 4'b0100, 4'b0000);

    // Short glitch on channel 3: no activity expected
    apply_stimulus(4'b1000, 3, "glitch");
    apply_stimulus(4'b0000, 10, "glitch");
    check_one("glitch_press_count", 4'(press_cnt[3]), 4'd0);

    // Simultaneous press on all channels
    apply_stimulus(4'b1111, 12, "simul");
    apply_stimulus(4'b0000, 10, "simul");

    random_phase(300);

    // Reset between edges while channel 0 is still qualifying
    apply_stimulus(4'b0000, 10, "pre_rst");
    apply_stimulus(4'b0001, 4, "pre_rst");
    #2 rst = 1'b1;
    model_reset();
    #1 check_output("async_rst");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 check_output("hold_rst");
    end
    rst = 1'b0;
    apply_stimulus(4'b0001, 12, "post_rst");
    check_one("post_rst_toggle0", key_toggle & 4'b0001, 4'b0001);

    random_phase(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
